// File: rtl/sigma_bus_arb.sv
// Two-master (CPU = m0, UDM = m1) to one-slave arbiter for the sigma data bus.
// Combinational grant with handshake lock, UDM starvation cap, and an in-order read-ID FIFO.
module sigma_bus_arb #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int OUTSTANDING_MAX = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             m0_req_i,
  input  logic                             m0_we_i,
  input  logic [ADDR_W-1:0]                m0_addr_i,
  input  logic [DATA_W/8-1:0]              m0_be_i,
  input  logic [DATA_W-1:0]                m0_wdata_i,
  output logic                             m0_ack_o,
  output logic                             m0_resp_o,
  output logic [DATA_W-1:0]                m0_rdata_o,
  input  logic                             m1_req_i,
  input  logic                             m1_we_i,
  input  logic [ADDR_W-1:0]                m1_addr_i,
  input  logic [DATA_W/8-1:0]              m1_be_i,
  input  logic [DATA_W-1:0]                m1_wdata_i,
  output logic                             m1_ack_o,
  output logic                             m1_resp_o,
  output logic [DATA_W-1:0]                m1_rdata_o,
  output logic                             s_req_o,
  output logic                             s_we_o,
  output logic [ADDR_W-1:0]                s_addr_o,
  output logic [DATA_W/8-1:0]              s_be_o,
  output logic [DATA_W-1:0]                s_wdata_o,
  input  logic                             s_ack_i,
  input  logic                             s_resp_i,
  input  logic [DATA_W-1:0]                s_rdata_i,
  output logic                             err_o,
  output logic [1:0]                       dbg_state_o,
  output logic [7:0]                       dbg_starve_cnt_o,
  output logic [$clog2(OUTSTANDING_MAX):0] dbg_fifo_count_o
);

  localparam int PW = $clog2(OUTSTANDING_MAX);
  localparam int CW = PW + 1;
  localparam logic [7:0]    LIMIT    = 8'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING_MAX);

  // The lock state also records the owner: a request is never switched mid-handshake.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_LOCK_M0 = 2'd1,
    ARB_LOCK_M1 = 2'd2
  } arb_state_t;

  arb_state_t        state_q, state_nxt;
  logic [7:0]        starve_cnt_q;
  logic [OUTSTANDING_MAX-1:0] id_mem;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              grant, gnt_req, gnt_we, xfer, push, pop;
  logic              fifo_full, fifo_empty, head;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head       = id_mem[rd_ptr_q];

  always_comb begin
    grant     = 1'b0;
    state_nxt = ARB_IDLE;
    unique case (state_q)
      ARB_LOCK_M0: grant = 1'b0;
      ARB_LOCK_M1: grant = 1'b1;
      default: begin
        if (m0_req_i && m1_req_i) grant = (starve_cnt_q != LIMIT);
        else                      grant = m1_req_i;
      end
    endcase
    gnt_req = grant ? m1_req_i : m0_req_i;
    gnt_we  = grant ? m1_we_i  : m0_we_i;
    // A read stalled on a full FIFO still holds the lock.
    s_req_o = rst_n_i & gnt_req & ~(~gnt_we & fifo_full);
    xfer    = s_req_o & s_ack_i;
    if (gnt_req && !xfer) state_nxt = grant ? ARB_LOCK_M1 : ARB_LOCK_M0;
  end

  assign s_we_o    = gnt_we;
  assign s_addr_o  = grant ? m1_addr_i  : m0_addr_i;
  assign s_be_o    = grant ? m1_be_i    : m0_be_i;
  assign s_wdata_o = grant ? m1_wdata_i : m0_wdata_i;
  assign m0_ack_o  = xfer & ~grant;
  assign m1_ack_o  = xfer & grant;

  assign push       = xfer & ~gnt_we;
  assign pop        = s_resp_i & ~fifo_empty;
  assign m0_resp_o  = rst_n_i & pop & ~head;
  assign m1_resp_o  = rst_n_i & pop & head;
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ARB_IDLE;
    else          state_q <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !m0_req_i)         starve_cnt_q <= '0;
    else if (xfer && !grant)           starve_cnt_q <= '0;
    else if (xfer && starve_cnt_q != LIMIT) starve_cnt_q <= starve_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr_q] <= grant;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_o    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (s_resp_i && fifo_empty) err_o <= 1'b1;
    end
  end

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_cnt_q;
  assign dbg_fifo_count_o = count_q;

endmodule
